// File: rtl/sub_8_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package sub_8_serial_pkg;

   localparam int unsigned SUB_DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sub_8_serial_fsub_1.sv
// One-bit full subtractor: d = x - y - bi, bo set when the bit borrows.
module fsub_1 (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/sub_8_serial.sv
// Bit-serial subtractor: d = a - b - bin over WIDTH cycles, LSB first, through one fsub_1.
module sub_8_serial
   import sub_8_serial_pkg::*;
#(
   parameter int unsigned WIDTH = SUB_DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] d,
   output logic             bo,
   output logic             ov,
   output logic             busy,
   output logic             done
);

   localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             r_state;
   state_t             w_next_state;
   logic               w_accept;
   logic               w_last;

   // r_ad holds the minuend and fills with result bits from the MSB side as it shifts
   logic [WIDTH-1:0]   r_ad;
   logic [WIDTH-1:0]   r_b;
   logic               r_br;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_a_msb;
   logic               r_b_msb;

   logic [WIDTH-1:0]   r_d;
   logic               r_bo;
   logic               r_ov;
   logic               r_done;

   logic               w_diff;
   logic               w_bout;
   logic [WIDTH-1:0]   w_res_next;

   fsub_1 u_fsub (
      .x  (r_ad[0]),
      .y  (r_b[0]),
      .bi (r_br),
      .d  (w_diff),
      .bo (w_bout)
   );

   assign w_res_next = {w_diff, r_ad[WIDTH-1:1]};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_next_state = ST_RUN;
            end
         end
         ST_RUN: begin
            if (r_cnt == CNT_LAST) begin
               w_last       = 1'b1;
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Operand capture, serial datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ad    <= '0;
         r_b     <= '0;
         r_br    <= 1'b0;
         r_cnt   <= '0;
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_d     <= '0;
         r_bo    <= 1'b0;
         r_ov    <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_ad    <= a;
            r_b     <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
         end else if (r_state == ST_RUN) begin
            r_ad  <= w_res_next;
            r_b   <= r_b >> 1;
            r_br  <= w_bout;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
               r_d    <= w_res_next;
               r_bo   <= w_bout;
               r_ov   <= (r_a_msb != r_b_msb) && (w_diff != r_a_msb);
               r_done <= 1'b1;
            end
         end
      end
   end

   assign d    = r_d;
   assign bo   = r_bo;
   assign ov   = r_ov;
   assign done = r_done;
   assign busy = (r_state != ST_IDLE);

endmodule

// File: doc/sub_8_serial.md
SUB_8_SERIAL -- requirements
Module: sub_8_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, request to begin a subtraction; sampled only in IDLE.
REQ-006 The block SHALL have port a, input, WIDTH, minuend; captured on the accepting edge.
REQ-007 The block SHALL have port b, input, WIDTH, subtrahend; captured on the accepting edge.
REQ-008 The block SHALL have port bin, input, 1, borrow-in; captured on the accepting edge.
REQ-009 The block SHALL have port d, output, WIDTH, registered difference a - b - bin, modulo 2^WIDTH.
REQ-010 The block SHALL have port bo, output, 1, registered borrow-out (1 when a < b + bin, unsigned).
REQ-011 The block SHALL have port ov, output, 1, registered signed overflow: (a[MSB] != b[MSB]) and (d[MSB] != a[MSB]).
REQ-012 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-013 The block SHALL have port done, output, 1, one-cycle pulse marking d/bo/ov valid.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-015 IDLE with start=1 at an edge SHALL latch a, b and bin into internal shift and borrow registers, clear the bit counter and enter RUN.
REQ-016 RUN SHALL process one bit per edge, LSB first, with a 1-bit full subtractor: diff = x^y^br, br_next = (~x&y) | (~(x^y)&br).
REQ-017 RUN SHALL shift diff into the result shift register MSB-side and update the borrow flop on each edge.
REQ-018 RUN SHALL last exactly WIDTH edges; on the edge where counter == WIDTH-1, the FSM SHALL copy the result to d, the final borrow to bo, and compute ov, then enter DONE.
REQ-019 DONE SHALL assert done=1 for exactly one cycle and return to IDLE on the next edge.
REQ-020 Latency: with start sampled at edge k, d/bo/ov and done SHALL become visible after edge k+WIDTH (k+8 at default).
REQ-021 Minimum issue period SHALL be WIDTH+2 edges (10 at default) with start held high.
REQ-022 start in RUN or DONE SHALL be ignored, with no queuing, and the operand registers SHALL be unaffected.
REQ-023 Changes on a, b or bin after the accepting edge SHALL have no effect on the result in progress.
REQ-024 d, bo and ov SHALL change only on the edge entering DONE and hold their value until the next completion.
REQ-025 Counter width SHALL be clog2(WIDTH); there SHALL be no wrap hazard, since the counter is reset on accept.

Reset
REQ-026 rst=1 at an edge SHALL force state IDLE, d=0, bo=0, ov=0, busy=0, done=0, and clear the shift registers, borrow flop and counter.
REQ-027 Reset SHALL take priority over start and over any RUN/DONE activity.
REQ-028 Reset mid-RUN SHALL abort the operation, produce no done pulse and no partial result on d, and leave the block ready for start on the first edge after rst deasserts.

Structure
REQ-029 A shared package SHALL hold the state encoding constants (IDLE, RUN, DONE) and the default WIDTH.
REQ-030 There SHALL be one combinational sub-module, fsub_1 (x, y, bi -> d, bo), instantiated once in the datapath.
REQ-031 All other logic SHALL be local to sub_8_serial; there SHALL be no combinational path from inputs to outputs.

Verification
REQ-032 Scenario 1: a=0x0F, b=0x0F, bin=0 -> d=0x00, bo=0, ov=0; done exactly 8 edges after the accepting edge, width 1 cycle.
REQ-033 Scenario 2: a=0x00, b=0x01, bin=0 -> d=0xFF, bo=1, ov=0; then a=0x55, b=0x2A, bin=1 -> d=0x2A, bo=0, ov=0.
REQ-034 Scenario 3: a=0x80, b=0x01, bin=0 -> d=0x7F, bo=0, ov=1; a=0x7F, b=0xFF, bin=0 -> d=0x80, bo=1, ov=1.
REQ-035 Scenario 4: accept a=0xF0, b=0x0F; at RUN edge 3 drive start=1 with a=0x00, b=0xFF -> second request ignored; result d=0xE1, bo=0; busy stays high throughout.
REQ-036 Scenario 5: rst=1 at RUN edge 4 -> next cycle busy=0, d=0, no done; a fresh start a=0x10, b=0x01 -> d=0x0F after 8 edges.
REQ-037 Scenario 6: start held high for 30 cycles with changing operands -> exactly 3 done pulses 10 edges apart, each result matching the operands present on its accepting edge.
